// File: rtl/veririsc_pkg.sv
// Shared VeriRISC constants: opcode and phase encodings, field widths,
// and the ALU-class opcode helper.
package veririsc_pkg;

    localparam int OPC_W = 3;
    localparam int PH_W  = 3;

    localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
    localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
    localparam logic [OPC_W-1:0] OP_AND = 3'd3;
    localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
    localparam logic [OPC_W-1:0] OP_STO = 3'd6;
    localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

    // The eight phases of one instruction cycle, in execution order.
    typedef enum logic [PH_W-1:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_e;

    // Opcodes that read an operand from memory into the accumulator.
    function automatic logic is_aluop(input logic [OPC_W-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/veririsc_ctrl_decode.sv
// Pure combinational decode from (phase, opcode, zero, halted) to the
// nine datapath control lines. Phases 0-3 never look at the opcode.
module veririsc_ctrl_decode
    import veririsc_pkg::*;
(
    input  phase_e           phase,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    input  logic             halted,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             halt,
    output logic             data_e,
    output logic             ld_ac,
    output logic             wr
);

    logic aluop;

    assign aluop = is_aluop(opcode);

    // Control decode: everything defaults low, a halted core only shows halt.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        ld_pc  = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                PH_INST_ADDR: begin
                    sel = 1'b1;
                end
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    halt   = (opcode == OP_HLT);
                    inc_pc = (opcode != OP_HLT);
                end
                PH_OP_FETCH: begin
                    rd = aluop;
                end
                PH_ALU_OP: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                PH_STORE: begin
                    rd     = aluop;
                    ld_ac  = aluop;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                    wr     = (opcode == OP_STO);
                end
                default: begin
                    sel = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/veririsc_controller.sv
// VeriRISC instruction-cycle sequencer: an 8-phase counter plus a sticky
// halted flag, with the control lines decoded combinationally from them.
module veririsc_controller
    import veririsc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    input  logic             zero,
    output logic             sel,
    output logic             rd,
    output logic             ld_ir,
    output logic             inc_pc,
    output logic             ld_pc,
    output logic             halt,
    output logic             data_e,
    output logic             ld_ac,
    output logic             wr,
    output logic [PH_W-1:0]  phase
);

    phase_e phase_q;
    phase_e phase_d;
    logic   halted_q;
    logic   halted_d;
    logic   wr_dec;

    // Phase and halted registers, cleared asynchronously by active-low rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next state: advance every cycle, but a HLT in the operand-address phase freezes at phase 4.
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if ((phase_q == PH_OP_ADDR) && (opcode == OP_HLT)) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_e'(phase_q + 3'd1);
            end
        end
    end

    veririsc_ctrl_decode u_decode (
        .phase  (phase_q),
        .opcode (opcode),
        .zero   (zero),
        .halted (halted_q),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .halt   (halt),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr_dec)
    );

    // A write strobe must never escape while reset is held.
    assign wr    = wr_dec & rst;
    assign phase = phase_q;

endmodule

// File: tb/tb_veririsc_controller.sv
// Self-checking bench for veririsc_controller: a table of hand-derived
// per-phase vectors, hand-written halt/reset sequences, then randomized
// opcodes checked against a per-phase activity-mask reference model.
module tb_veririsc_controller;
    import veririsc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
    logic [2:0] phase;
    logic [8:0] dut_ctrl;

    int checks = 0;
    int errors = 0;

    // Control vector order: {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}
    localparam logic [8:0] C_P0   = 9'b1_0000_0000;
    localparam logic [8:0] C_P1   = 9'b1_1000_0000;
    localparam logic [8:0] C_P23  = 9'b1_1100_0000;
    localparam logic [8:0] C_INC  = 9'b0_0010_0000;
    localparam logic [8:0] C_NONE = 9'b0_0000_0000;
    localparam logic [8:0] C_RD   = 9'b0_1000_0000;
    localparam logic [8:0] C_RDAC = 9'b0_1000_0010;
    localparam logic [8:0] C_DE   = 9'b0_0000_0100;
    localparam logic [8:0] C_DEWR = 9'b0_0000_0101;
    localparam logic [8:0] C_LDPC = 9'b0_0001_0000;
    localparam logic [8:0] C_HALT = 9'b0_0000_1000;

    typedef struct {
        logic [2:0] op;
        logic       z;
        logic [8:0] ctrl;
        logic [2:0] ph;
    } vec_t;

    vec_t vecs[$];

    int m_phase;
    bit m_halted;

    veririsc_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .ld_ir  (ld_ir),
        .inc_pc (inc_pc),
        .ld_pc  (ld_pc),
        .halt   (halt),
        .data_e (data_e),
        .ld_ac  (ld_ac),
        .wr     (wr),
        .phase  (phase)
    );

    assign dut_ctrl = {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr};

    always #5 clk = ~clk;

    // Reference model: for each control, the set of phases (as an 8-bit mask) where it is active.
    function automatic logic [8:0] modelCtrl(input int ph, input bit halted,
                                             input logic [2:0] op, input logic z);
        logic [7:0] sel_m, rd_m, ldir_m, inc_m, ldpc_m, halt_m, de_m, ldac_m, wr_m;
        logic [2:0] p;
        bit         alu;
        p      = ph[2:0];
        alu    = (op >= 3'd2) && (op <= 3'd5);
        sel_m  = 8'b0000_1111;
        rd_m   = 8'b0000_1110 | (alu ? 8'b1110_0000 : 8'h00);
        ldir_m = 8'b0000_1100;
        inc_m  = ((op != 3'd0) ? 8'h10 : 8'h00) | (((op == 3'd1) && z) ? 8'h40 : 8'h00);
        ldpc_m = (op == 3'd7) ? 8'hC0 : 8'h00;
        halt_m = (op == 3'd0) ? 8'h10 : 8'h00;
        de_m   = (op == 3'd6) ? 8'hC0 : 8'h00;
        ldac_m = alu ? 8'h80 : 8'h00;
        wr_m   = (op == 3'd6) ? 8'h80 : 8'h00;
        if (halted) return C_HALT;
        return {sel_m[p], rd_m[p], ldir_m[p], inc_m[p], ldpc_m[p],
                halt_m[p], de_m[p], ldac_m[p], wr_m[p]};
    endfunction

    task automatic addVec(input logic [2:0] op, input logic z, input logic [8:0] ctrl);
        vec_t v;
        v.op   = op;
        v.z    = z;
        v.ctrl = ctrl;
        v.ph   = 3'(vecs.size() % 8);
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] exp_ctrl, input logic [2:0] exp_ph);
        checks++;
        if (dut_ctrl !== exp_ctrl || phase !== exp_ph) begin
            errors++;
            $display("[TB] FAIL %s ctrl=%b expected %b phase=%0d expected %0d",
                     name, dut_ctrl, exp_ctrl, phase, exp_ph);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int halt_cycles;
        logic [2:0] op;
        logic       z;

        // Phases 0-3 use assorted opcodes to show the fetch half ignores them.
        addVec(3'd7, 1'b0, C_P0); addVec(3'd0, 1'b1, C_P1); addVec(3'd5, 1'b0, C_P23); addVec(OP_ADD, 1'b0, C_P23);
        addVec(OP_ADD, 1'b0, C_INC); addVec(OP_ADD, 1'b0, C_RD); addVec(OP_ADD, 1'b1, C_RD); addVec(OP_ADD, 1'b0, C_RDAC);
        addVec(3'd3, 1'b1, C_P0); addVec(3'd6, 1'b0, C_P1); addVec(OP_STO, 1'b0, C_P23); addVec(OP_STO, 1'b0, C_P23);
        addVec(OP_STO, 1'b0, C_INC); addVec(OP_STO, 1'b0, C_NONE); addVec(OP_STO, 1'b1, C_DE); addVec(OP_STO, 1'b0, C_DEWR);
        addVec(3'd1, 1'b0, C_P0); addVec(3'd2, 1'b0, C_P1); addVec(OP_JMP, 1'b0, C_P23); addVec(OP_JMP, 1'b1, C_P23);
        addVec(OP_JMP, 1'b1, C_INC); addVec(OP_JMP, 1'b0, C_NONE); addVec(OP_JMP, 1'b1, C_LDPC); addVec(OP_JMP, 1'b0, C_LDPC);
        addVec(3'd4, 1'b1, C_P0); addVec(3'd4, 1'b1, C_P1); addVec(OP_SKZ, 1'b1, C_P23); addVec(OP_SKZ, 1'b1, C_P23);
        addVec(OP_SKZ, 1'b1, C_INC); addVec(OP_SKZ, 1'b1, C_NONE); addVec(OP_SKZ, 1'b1, C_INC); addVec(OP_SKZ, 1'b1, C_NONE);
        addVec(3'd5, 1'b0, C_P0); addVec(3'd6, 1'b0, C_P1); addVec(OP_SKZ, 1'b0, C_P23); addVec(OP_SKZ, 1'b0, C_P23);
        addVec(OP_SKZ, 1'b0, C_INC); addVec(OP_SKZ, 1'b1, C_NONE); addVec(OP_SKZ, 1'b0, C_NONE); addVec(OP_SKZ, 1'b1, C_NONE);

        rst = 1'b0;
        #2;
        checkOutput("reset_state", C_P0, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].z);
            checkOutput($sformatf("table_%0d", i), vecs[i].ctrl, vecs[i].ph);
            tick();
        end

        // HLT: normal fetch, halt in phase 4, then frozen at phase 4.
        applyStimulus(OP_HLT, 1'b0); checkOutput("hlt_p0", C_P0, 3'd0); tick();
        applyStimulus(OP_HLT, 1'b0); checkOutput("hlt_p1", C_P1, 3'd1); tick();
        applyStimulus(OP_HLT, 1'b0); checkOutput("hlt_p2", C_P23, 3'd2); tick();
        applyStimulus(OP_HLT, 1'b0); checkOutput("hlt_p3", C_P23, 3'd3); tick();
        applyStimulus(OP_HLT, 1'b0); checkOutput("hlt_p4", C_HALT, 3'd4); tick();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
            checkOutput($sformatf("halted_%0d", i), C_HALT, 3'd4);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checkOutput("halt_async_reset", C_P0, 3'd0);
        #1;
        rst = 1'b1;
        tick();

        // Resume after reset, run STO to phase 7, then reset asynchronously.
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p1", C_P1, 3'd1); tick();
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p2", C_P23, 3'd2); tick();
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p3", C_P23, 3'd3); tick();
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p4", C_INC, 3'd4); tick();
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p5", C_NONE, 3'd5); tick();
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p6", C_DE, 3'd6); tick();
        applyStimulus(OP_STO, 1'b0); checkOutput("resume_p7", C_DEWR, 3'd7);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("sto_async_reset", C_P0, 3'd0);
        rst = 1'b1;

        // Randomized run against the mask model, with occasional HLT and mid-cycle resets.
        m_phase     = 0;
        m_halted    = 1'b0;
        halt_cycles = 0;
        for (int n = 0; n < 600; n++) begin
            op = 3'($urandom_range(7, 0));
            if (op == OP_HLT && $urandom_range(7, 0) != 0) op = OP_ADD;
            z = 1'($urandom_range(1, 0));
            applyStimulus(op, z);
            checkOutput($sformatf("rand_%0d", n), modelCtrl(m_phase, m_halted, op, z), 3'(m_phase));
            checks++;
            if (inc_pc && ld_pc) begin
                errors++;
                $display("[TB] FAIL pc_exclusive_%0d inc_pc=%b ld_pc=%b expected not both 1", n, inc_pc, ld_pc);
            end
            tick();
            if (!m_halted) begin
                if (m_phase == 4 && op == 3'd0) m_halted = 1'b1;
                else m_phase = (m_phase + 1) % 8;
            end
            if (m_halted) halt_cycles++;
            if (halt_cycles >= 4) begin
                #2;
                rst = 1'b0;
                m_phase     = 0;
                m_halted    = 1'b0;
                halt_cycles = 0;
                #1;
                checkOutput($sformatf("rand_reset_%0d", n), modelCtrl(0, 1'b0, opcode, zero), 3'd0);
                #1;
                rst = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
